set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/set_assoc_cache.sv | 151 +++++++++++++++
 tb/tb_set_assoc_cache.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache.sv
// Set-associative, read-only cache with per-set round-robin replacement.
// A miss refills the whole block from backing memory, one word per memValid.
// state   | meaning
// IDLE    | waiting for req; address is latched on req
// LOOKUP  | parallel tag compare across all ways of the indexed set
// REFILL  | fetching block words 0..BLOCKSIZE-1 into the victim way
// RESPOND | one-cycle ready pulse with the requested word on dataOut
module set_assoc_cache #(
   parameter int ADDRESSL  = 15,
   parameter int WORD      = 32,
   parameter int BLOCKSIZE = 4,
   parameter int SETS      = 64,
   parameter int WAYS      = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic [ADDRESSL-1:0] address,
   output logic [WORD-1:0]     dataOut,
   output logic                ready,
   output logic [ADDRESSL-1:0] numOfHits,
   output logic [ADDRESSL-1:0] numOfMisses,
   output logic                memReq,
   output logic [ADDRESSL-1:0] memAddress,
   input  logic [WORD-1:0]     memData,
   input  logic                memValid
);

   localparam int OFFW = $clog2(BLOCKSIZE);
   localparam int IDXW = $clog2(SETS);
   localparam int TAGW = ADDRESSL - OFFW - IDXW;
   localparam int PW   = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;
   state_t state, state_nxt;

   logic [ADDRESSL-1:0] addr_q;
   logic [TAGW-1:0]     tag;
   logic [IDXW-1:0]     idx;
   logic [OFFW-1:0]     off;

   logic [WAYS-1:0]     valid_q [SETS];
   logic [PW-1:0]       ptr_q   [SETS];
   logic [TAGW-1:0]     tag_q   [WAYS][SETS];
   logic [WORD-1:0]     data_q  [WAYS][SETS][BLOCKSIZE];

   logic [PW-1:0]       victim_q, victim_c, hit_way;
   logic                hit, has_invalid;
   logic [OFFW-1:0]     k_q;
   logic                last_word;

   assign tag       = addr_q[ADDRESSL-1 -: TAGW];
   assign idx       = addr_q[OFFW +: IDXW];
   assign off       = addr_q[OFFW-1:0];
   assign last_word = memValid && (k_q == OFFW'(BLOCKSIZE - 1));

   // Tag compare and victim choice; descending scan so the lowest index wins.
   always_comb begin
      hit         = 1'b0;
      hit_way     = '0;
      has_invalid = 1'b0;
      victim_c    = ptr_q[idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[idx][w]) begin
            has_invalid = 1'b1;
            victim_c    = PW'(w);
         end
         if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
            hit     = 1'b1;
            hit_way = PW'(w);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and Moore outputs; memAddress is zero whenever not refilling.
   always_comb begin
      state_nxt  = state;
      ready      = 1'b0;
      memReq     = 1'b0;
      memAddress = '0;
      case (state)
         IDLE:    if (req) state_nxt = LOOKUP;
         LOOKUP:  state_nxt = hit ? RESPOND : REFILL;
         REFILL: begin
            memReq     = 1'b1;
            memAddress = {tag, idx, k_q};
            if (last_word) state_nxt = RESPOND;
         end
         RESPOND: begin
            ready     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control datapath: address latch, counters, refill index, valid bits, pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= '0;
         k_q         <= '0;
         victim_q    <= '0;
         dataOut     <= '0;
         numOfHits   <= '0;
         numOfMisses <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else begin
         case (state)
            IDLE: if (req) addr_q <= address;
            LOOKUP: begin
               if (hit) begin
                  dataOut <= data_q[hit_way][idx][off];
                  if (numOfHits != '1) numOfHits <= numOfHits + 1'b1;
               end else begin
                  if (numOfMisses != '1) numOfMisses <= numOfMisses + 1'b1;
                  victim_q <= victim_c;
                  k_q      <= '0;
                  // Pointer only advances when it actually chose the victim.
                  if (!has_invalid && WAYS > 1) ptr_q[idx] <= ptr_q[idx] + 1'b1;
               end
            end
            REFILL: begin
               if (memValid) begin
                  k_q <= k_q + 1'b1;
                  if (k_q == off) dataOut <= memData;
                  if (last_word) valid_q[idx][victim_q] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Data and tag arrays carry no reset; validity alone decides what is usable.
   always_ff @(posedge clk) begin
      if (state == REFILL && memValid) begin
         data_q[victim_q][idx][k_q] <= memData;
         if (last_word) tag_q[victim_q][idx] <= tag;
      end
   end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: expected words are queued at request
// time and popped when ready pulses; backing memory returns 0xA0000000+addr.
module tb_set_assoc_cache;

   localparam int AL = 15;
   localparam int W  = 32;
   localparam int BS = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic [AL-1:0] address = '0;
   logic [W-1:0]  dataOut;
   logic          ready;
   logic [AL-1:0] numOfHits, numOfMisses;
   logic          memReq;
   logic [AL-1:0] memAddress;
   logic [W-1:0]  memData;
   logic          memValid;

   int checks   = 0;
   int failures = 0;
   bit stall    = 1'b0;
   int cyc      = 0;

   logic [W-1:0]  sb_q[$];
   logic [AL-1:0] acc_q[$];
   bit            saw_memreq = 1'b0;
   bit            prev_pending = 1'b0;
   logic [AL-1:0] prev_addr = '0;

   set_assoc_cache dut (
      .clk(clk), .rst(rst), .req(req), .address(address),
      .dataOut(dataOut), .ready(ready),
      .numOfHits(numOfHits), .numOfMisses(numOfMisses),
      .memReq(memReq), .memAddress(memAddress),
      .memData(memData), .memValid(memValid)
   );

   always #5 clk = ~clk;

   assign memData  = 32'hA000_0000 + {17'b0, memAddress};
   assign memValid = stall ? (cyc % 4 == 3) : 1'b1;

   // Stall phase counter moves between edges so memValid is stable at both.
   always begin
      @(posedge clk);
      #2;
      cyc++;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor: refill address log, hold-while-stalled check, scoreboard pop.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_pending) check_val("addr_hold", 32'(memAddress), 32'(prev_addr));
         prev_pending = memReq && !memValid;
         prev_addr    = memAddress;
         if (memReq) saw_memreq = 1'b1;
         if (memReq && memValid) acc_q.push_back(memAddress);
         if (ready) begin
            if (sb_q.size() == 0) check_val("spurious_ready", 32'(ready), 32'd0);
            else                  check_val("dataOut", dataOut, sb_q.pop_front());
         end
      end else begin
         prev_pending = 1'b0;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      req = 1'b0;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_ready",   32'(ready),       32'd0);
      check_val("rst_memreq",  32'(memReq),      32'd0);
      check_val("rst_hits",    32'(numOfHits),   32'd0);
      check_val("rst_misses",  32'(numOfMisses), 32'd0);
      check_val("rst_dataout", dataOut,          32'd0);
      check_val("rst_memaddr", 32'(memAddress),  32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One request; exp_lat counts the cycle holding ready (0 skips the check).
   task automatic do_req(input logic [AL-1:0] a, input bit exp_hit, input int exp_lat);
      logic [W-1:0] exp_d;
      int n;
      exp_d = 32'hA000_0000 + {17'b0, a};
      @(negedge clk);
      req        = 1'b1;
      address    = a;
      acc_q.delete();
      saw_memreq = 1'b0;
      sb_q.push_back(exp_d);
      @(posedge clk);
      #1;
      req = 1'b0;
      n   = 0;
      while (!ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (stall && n == 3) begin
            req     = 1'b1;
            address = 15'h0300;
         end
         if (stall && n == 4) begin
            req     = 1'b0;
            address = a;
         end
      end
      check_val("ready_seen", 32'(ready), 32'd1);
      if (exp_lat != 0) check_val("latency", 32'(n + 1), 32'(exp_lat));
      @(posedge clk);
      #1;
      check_val("ready_pulse", 32'(ready),  32'd0);
      check_val("dout_hold",   dataOut,     exp_d);
      check_val("memreq_idle", 32'(memReq), 32'd0);
      if (exp_hit) begin
         check_val("hit_no_memreq", 32'(saw_memreq), 32'd0);
      end else begin
         check_val("refill_words", 32'(acc_q.size()), 32'(BS));
         for (int i = 0; i < acc_q.size() && i < BS; i++)
            check_val("refill_addr", 32'(acc_q[i]), 32'({a[AL-1:2], 2'(i)}));
      end
      check_val("sb_drained", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic check_counts(input string tag, input int hits, input int misses);
      check_val({tag, "_hits"},   32'(numOfHits),   32'(hits));
      check_val({tag, "_misses"}, 32'(numOfMisses), 32'(misses));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Cold miss then hit in the same block.
      do_req(15'h0005, 1'b0, 6);
      check_counts("cold", 0, 1);
      do_req(15'h0006, 1'b1, 2);
      check_counts("hit", 1, 1);

      // Conflict traffic in set 1 with round-robin replacement.
      do_reset();
      do_req(15'h0004, 1'b0, 6);
      do_req(15'h0104, 1'b0, 6);
      do_req(15'h0204, 1'b0, 6);
      do_req(15'h0104, 1'b1, 2);
      do_req(15'h0004, 1'b0, 6);
      check_counts("conflict", 1, 4);
      // Ways now hold tags 2 and 0; the pointer has wrapped back to way 0.
      do_req(15'h0204, 1'b1, 2);
      do_req(15'h0104, 1'b0, 6);
      do_req(15'h0004, 1'b1, 2);
      check_counts("rr", 3, 5);

      // Stalled memory, with a stray req during the refill that must be ignored.
      stall = 1'b1;
      do_req(15'h0010, 1'b0, 0);
      stall = 1'b0;
      do_req(15'h0012, 1'b1, 2);
      check_counts("stall", 4, 6);

      // Reset in the middle of a refill after two accepted words.
      @(negedge clk);
      req     = 1'b1;
      address = 15'h0020;
      acc_q.delete();
      @(posedge clk);
      #1;
      req = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check_val("partial_words", 32'(acc_q.size()), 32'd2);
      rst = 1'b1;
      #1;
      check_val("midrst_memreq",  32'(memReq),      32'd0);
      check_val("midrst_memaddr", 32'(memAddress),  32'd0);
      check_val("midrst_ready",   32'(ready),       32'd0);
      check_counts("midrst", 0, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      do_req(15'h0021, 1'b0, 6);
      check_counts("after_rst", 0, 1);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
